// File: rtl/itcm_boot_fetch.sv
`default_nettype none
// ============================================================================
// Module   : itcm_boot_fetch
// Purpose  : AHB-Lite read master copying a block of boot-memory words into
//            the ITCM auto-load write port; holds busy until the copy ends.
// Revision : 1.0  initial release
// ============================================================================
module itcm_boot_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TCM_AW     = 13
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  tcm_wr_en,
  output logic [TCM_AW-1:0]     tcm_wr_addr,
  output logic [DATA_WIDTH-1:0] tcm_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;

  // ERR1: first error cycle seen while issuing; ERR2: seen while draining
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XFER  = 3'd1,
    S_DRAIN = 3'd2,
    S_ERR1  = 3'd3,
    S_ERR2  = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_issue_cnt;
  logic [CNT_WIDTH-1:0]  r_recv_cnt;
  logic                  r_dphase;

  logic [ADDR_WIDTH-1:0] w_src_aligned;
  logic [CNT_WIDTH-1:0]  w_issue_next;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_active;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_err_first;
  logic                  w_err_last;

  assign HWRITE = 1'b0;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;

  assign w_src_aligned = src_base & ~(ADDR_WIDTH'(3));
  assign w_issue_next  = r_issue_cnt + CNT_WIDTH'(1);
  assign w_next_addr   = r_base + ADDR_WIDTH'({w_issue_next, 2'b00});
  assign w_active      = (r_state == S_XFER) || (r_state == S_DRAIN);
  assign w_accept      = HREADY && r_dphase;
  assign w_capture     = w_active && w_accept && !HRESP;
  assign w_err_first   = r_dphase && !HREADY && HRESP;
  assign w_err_last    = w_accept && HRESP;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_count     <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_dphase    <= 1'b0;
      HADDR       <= '0;
      HTRANS      <= c_htrans_idle;
      tcm_wr_en   <= 1'b0;
      tcm_wr_addr <= '0;
      tcm_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      tcm_wr_en <= 1'b0;
      done      <= 1'b0;

      // A completed NONSEQ address phase opens a data phase in the next cycle
      if (HREADY) begin
        r_dphase <= (HTRANS == c_htrans_nonseq);
      end

      if (w_capture) begin
        tcm_wr_en   <= 1'b1;
        tcm_wr_data <= HRDATA;
        tcm_wr_addr <= r_recv_cnt[TCM_AW-1:0];
        r_recv_cnt  <= r_recv_cnt + CNT_WIDTH'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            error       <= 1'b0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              r_base  <= w_src_aligned;
              r_count <= word_count;
              HADDR   <= w_src_aligned;
              HTRANS  <= c_htrans_nonseq;
              busy    <= 1'b1;
              r_state <= S_XFER;
            end
          end
        end

        S_XFER: begin
          if (w_err_first) begin
            HTRANS  <= c_htrans_idle;
            r_state <= S_ERR1;
          end else if (w_err_last) begin
            HTRANS   <= c_htrans_idle;
            r_dphase <= 1'b0;
            error    <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end else if (HREADY) begin
            r_issue_cnt <= w_issue_next;
            if (w_issue_next == r_count) begin
              HTRANS  <= c_htrans_idle;
              r_state <= S_DRAIN;
            end else begin
              HADDR <= w_next_addr;
            end
          end
        end

        S_DRAIN: begin
          if (w_err_first) begin
            r_state <= S_ERR2;
          end else if (w_err_last) begin
            r_dphase <= 1'b0;
            error    <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end else if (!r_dphase) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_ERR1, S_ERR2: begin
          if (HREADY) begin
            r_dphase <= 1'b0;
            error    <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
